imm_decode_stage: RTL and testbench
===================================

Name: imm_decode_stage

Overview:
- Decode pipeline stage that sequences instructions through immediate generation between fetch and execute.
- Accepts 32-bit instructions over a valid/ready handshake, classifies the format (I/S/B/U/J) and produces the sign-extended IMMSIZE immediate.
- Buffers up to two decoded entries (main + skid) so ready does not combinationally depend on downstream ready.
- Provides flush for branch redirect.

Parameters:
INSTRSIZE, 32, instruction width (only 32 supported)
IMMSIZE, 64, immediate output width; sign-extended from instruction bit 31

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
flush  input  1  synchronous flush; discards all buffered entries
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept; registered
in_instruction  input  INSTRSIZE  fetched instruction
out_valid  output  1  decoded entry available
out_ready  input  1  downstream accepts
out_instruction  output  INSTRSIZE  instruction of head entry
out_immediate  output  IMMSIZE  signed immediate of head entry
out_imm_type  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J

Behaviour:
- Reset (rst_n low, async): count=0; in_ready=1; out_valid=0; out_instruction=0; out_immediate=0; out_imm_type=0.
- Accept when in_valid&&in_ready; pop when out_valid&&out_ready, both at rising edge.
- Latency: an instruction accepted in cycle N appears at the outputs in cycle N+1 when the stage was empty or popping.
- Decode happens on entry; buffers store instruction, immediate and type.
- States by count:
  - EMPTY(0): accept -> ONE.
  - ONE(1): accept only -> TWO; pop only -> EMPTY; accept+pop -> ONE (new entry becomes head next cycle).
  - TWO(2): in_ready=0, no accept; pop -> ONE (skid moves to head).
- in_ready = (count<2), registered, so it deasserts the cycle after TWO is reached. in_ready never depends on out_ready in the same cycle.
- out_valid = (count>0). Head outputs hold stable while out_valid&&!out_ready.
- Order is strictly FIFO. No entry is duplicated or dropped except on flush.
- Flush takes priority over accept and pop in the same cycle:
  - next state EMPTY, out_valid=0, in_ready=1;
  - any instruction presented in the flush cycle is dropped;
  - a pop coinciding with flush is still seen by downstream as a transfer, and downstream must also flush.
- Immediate rules, by opcode bits [6:0]. Immediates are sign-extended from inst[31] to IMMSIZE.
  - I (0000011, 0010011, 0011011, 1100111, 1110011): inst[31:20]
  - S (0100011, 0100111): {inst[31:25], inst[11:7]}
  - B (1100011): {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U (0110111, 0010111): {inst[31:12], 12'b0}
  - J (1101111): {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - Any other opcode: immediate 0, type NONE.

Optional Feature:
- Macro: IMM_DECODE_ILLEGAL_CHECK_EN.
- When defined: adds output out_illegal (1 bit), stored per entry. It is 1 when inst[1:0]!=2'b11 or the opcode is not in the table above. Such entries carry immediate 0 and type NONE. Reset value 0; the output is qualified by out_valid.
- When undefined: port absent. Non-matching opcodes still produce immediate 0 and type NONE with no flag.

Test Plan:
- I-type: push 0xFCE08713, then 0x00F08713 with out_ready=1 -> outputs 1 cycle after each accept: imm -50 (0xFFFFFFFFFFFFFFCE), type 1; then imm 15, type 1.
- S/B: 0xFCE12723 -> imm -50, type 2. 0xF8A98EE3 -> imm -100, type 3. U/J: 0x12345037 -> imm 0x12345000, type 4. 0x0040006F -> imm 4, type 5.
- Backpressure: out_ready=0, offer A,B,C back-to-back. A and B are accepted, in_ready=0 from the cycle after B, C is held. Raise out_ready -> A, B, C emerge in order with no loss or duplication. in_ready returns to 1 one cycle after the first pop.
- Simultaneous accept+pop in ONE with continuous streaming of 10 instructions -> one output per cycle, count stays 1, in_ready constantly 1.
- Flush in TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1. The flushed-cycle instruction never appears at the outputs.
- Reset mid-operation: drop rst_n asynchronously while count=2 -> outputs go to reset values immediately without waiting for a clock edge. After release, the first accepted instruction decodes correctly.
- With IMM_DECODE_ILLEGAL_CHECK_EN: 0x0000000B -> out_illegal=1, imm 0, type 0. 0xFCE08713 -> out_illegal=0.

Source files
------------

// File: rtl/imm_decode_stage.sv
// Decode stage: classifies I/S/B/U/J formats and builds the sign-extended immediate.
// Two-entry buffer (head + skid). Optional out_illegal via IMM_DECODE_ILLEGAL_CHECK_EN.
module imm_decode_stage #(
  parameter int INSTRSIZE = 32,
  parameter int IMMSIZE   = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTRSIZE-1:0] in_instruction,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INSTRSIZE-1:0] out_instruction,
  output logic [IMMSIZE-1:0]   out_immediate,
`ifdef IMM_DECODE_ILLEGAL_CHECK_EN
  output logic                 out_illegal,
`endif
  output logic [2:0]           out_imm_type
);

  typedef struct packed {
    logic [INSTRSIZE-1:0] instruction;
    logic [IMMSIZE-1:0]   immediate;
    logic [2:0]           imm_type;
`ifdef IMM_DECODE_ILLEGAL_CHECK_EN
    logic                 illegal;
`endif
  } entry_t;

  function automatic entry_t decode(input logic [INSTRSIZE-1:0] inst);
    entry_t      e;
    logic [6:0]  op;
    logic [31:0] imm32;
    logic [2:0]  t;
    logic        is_i, is_s, is_b, is_u, is_j;
    op    = inst[6:0];
    is_i  = op inside {7'b0000011, 7'b0010011, 7'b0011011,
                       7'b1100111, 7'b1110011};
    is_s  = op inside {7'b0100011, 7'b0100111};
    is_b  = (op == 7'b1100011);
    is_u  = op inside {7'b0110111, 7'b0010111};
    is_j  = (op == 7'b1101111);
    imm32 = '0;
    t     = 3'd0;
    unique case (1'b1)
      is_i: begin
        imm32 = {{20{inst[31]}}, inst[31:20]};
        t     = 3'd1;
      end
      is_s: begin
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        t     = 3'd2;
      end
      is_b: begin
        imm32 = {{19{inst[31]}}, inst[31], inst[7],
                 inst[30:25], inst[11:8], 1'b0};
        t     = 3'd3;
      end
      is_u: begin
        imm32 = {inst[31:12], 12'b0};
        t     = 3'd4;
      end
      is_j: begin
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12],
                 inst[20], inst[30:21], 1'b0};
        t     = 3'd5;
      end
      default: begin
        imm32 = '0;
        t     = 3'd0;
      end
    endcase
    e.instruction = inst;
    e.immediate   = IMMSIZE'($signed(imm32));
    e.imm_type    = t;
`ifdef IMM_DECODE_ILLEGAL_CHECK_EN
    // every table opcode ends in 2'b11, so no match covers both cases
    e.illegal     = (t == 3'd0);
`endif
    return e;
  endfunction

  logic [1:0] count;
  entry_t     head;
  entry_t     skid;
  entry_t     dec;
  logic       accept;
  logic       pop;

  assign dec    = decode(in_instruction);
  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= 2'd0;
      in_ready <= 1'b1;
      head     <= '0;
      skid     <= '0;
    end else if (flush) begin
      count    <= 2'd0;
      in_ready <= 1'b1;
    end else begin
      case (count)
        2'd0: begin
          if (accept) begin
            head  <= dec;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (accept && pop) begin
            head <= dec;
          end else if (accept) begin
            skid     <= dec;
            count    <= 2'd2;
            in_ready <= 1'b0;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head     <= skid;
            count    <= 2'd1;
            in_ready <= 1'b1;
          end
        end
        default: begin
          count    <= 2'd0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign out_valid       = (count != 2'd0);
  assign out_instruction = head.instruction;
  assign out_immediate   = head.immediate;
  assign out_imm_type    = head.imm_type;
`ifdef IMM_DECODE_ILLEGAL_CHECK_EN
  assign out_illegal     = out_valid && head.illegal;
`endif

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: formats, backpressure,
// streaming, flush and async reset, with hand-computed expectations.
module tb_imm_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instruction;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [63:0] out_immediate;
  logic [2:0]  out_imm_type;
`ifdef IMM_DECODE_ILLEGAL_CHECK_EN
  logic        out_illegal;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  imm_decode_stage #(.INSTRSIZE(32), .IMMSIZE(64)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instruction  (in_instruction),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_immediate   (out_immediate),
`ifdef IMM_DECODE_ILLEGAL_CHECK_EN
    .out_illegal     (out_illegal),
`endif
    .out_imm_type    (out_imm_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] inst,
                          input logic [63:0] imm, input logic [2:0] t);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_inst"}, 64'(out_instruction), 64'(inst));
    chk({tag, "_imm"}, out_immediate, imm);
    chk({tag, "_type"}, 64'(out_imm_type), 64'(t));
  endtask

  task automatic push(input logic [31:0] inst);
    in_valid       = 1'b1;
    in_instruction = inst;
    step();
    in_valid       = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    flush          = 1'b0;
    in_valid       = 1'b0;
    in_instruction = '0;
    out_ready      = 1'b1;
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_inst", 64'(out_instruction), 64'd0);
    chk("rst_imm", out_immediate, 64'd0);
    chk("rst_type", 64'(out_imm_type), 64'd0);
    rst_n = 1'b1;
    step();

    // formats, one output per accept with out_ready high
    push(32'hFCE08713);
    chk_head("i_neg", 32'hFCE08713, 64'hFFFFFFFFFFFFFFCE, 3'd1);
    push(32'h00F08713);
    chk_head("i_pos", 32'h00F08713, 64'd15, 3'd1);
    push(32'hFCE12723);
    chk_head("s", 32'hFCE12723, 64'hFFFFFFFFFFFFFFCE, 3'd2);
    push(32'hF8A98EE3);
    chk_head("b", 32'hF8A98EE3, 64'hFFFFFFFFFFFFFF9C, 3'd3);
    push(32'h12345037);
    chk_head("u", 32'h12345037, 64'h0000000012345000, 3'd4);
    push(32'h0040006F);
    chk_head("j", 32'h0040006F, 64'd4, 3'd5);
    push(32'h0000000B);
    chk_head("none", 32'h0000000B, 64'd0, 3'd0);
`ifdef IMM_DECODE_ILLEGAL_CHECK_EN
    chk("ill_set", 64'(out_illegal), 64'd1);
    push(32'hFCE08713);
    chk("ill_clr", 64'(out_illegal), 64'd0);
`endif
    step();
    chk("drain_valid", 64'(out_valid), 64'd0);

    // backpressure: A, B accepted, C held until pops start
    out_ready      = 1'b0;
    in_valid       = 1'b1;
    in_instruction = 32'h00100013;
    step();
    chk("bp_ready_one", 64'(in_ready), 64'd1);
    in_instruction = 32'h00200013;
    step();
    in_instruction = 32'h00300013;
    chk("bp_ready_two", 64'(in_ready), 64'd0);
    chk_head("bp_a_hold", 32'h00100013, 64'd1, 3'd1);
    step();
    chk("bp_ready_hold", 64'(in_ready), 64'd0);
    chk_head("bp_a_hold2", 32'h00100013, 64'd1, 3'd1);
    out_ready = 1'b1;
    step();
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    chk_head("bp_b", 32'h00200013, 64'd2, 3'd1);
    step();
    in_valid = 1'b0;
    chk_head("bp_c", 32'h00300013, 64'd3, 3'd1);
    step();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // continuous streaming through ONE
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_instruction = (32'(k) << 20) | 32'h13;
      step();
      chk("st_ready", 64'(in_ready), 64'd1);
      chk_head("st", (32'(k) << 20) | 32'h13, 64'(k), 3'd1);
    end
    in_valid = 1'b0;
    step();
    chk("st_empty", 64'(out_valid), 64'd0);

    // flush in TWO with a live input
    out_ready = 1'b0;
    push(32'h00A00013);
    push(32'h00B00013);
    chk("fl_full", 64'(in_ready), 64'd0);
    flush          = 1'b1;
    in_valid       = 1'b1;
    in_instruction = 32'h00C00013;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    chk("fl_dropped", 64'(out_valid), 64'd0);
    push(32'h00D00013);
    chk_head("fl_after", 32'h00D00013, 64'd13, 3'd1);
    step();

    // async reset while holding two entries
    out_ready = 1'b0;
    push(32'hFCE12723);
    push(32'h0040006F);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_ready", 64'(in_ready), 64'd1);
    chk("ar_inst", 64'(out_instruction), 64'd0);
    chk("ar_imm", out_immediate, 64'd0);
    chk("ar_type", 64'(out_imm_type), 64'd0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    push(32'h12345037);
    chk_head("ar_after", 32'h12345037, 64'h0000000012345000, 3'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
